// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches to instruction memory,
// buffers in-order responses with their PCs, and hands them to decode.
// Redirects flush the buffer and drop responses that are still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        to_decode_valid,
    input  logic        to_decode_ready,
    output logic [31:0] to_decode_data,
    output logic [31:0] to_decode_pc,
    output logic        fetch_error
);

    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]     CAP      = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FULL     = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic          error;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   in_use;
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;

    // Issue gating, buffer handshakes and pointer wrap, all derived from current state
    always_comb begin
        in_use          = {1'b0, outstanding} + {1'b0, count};
        imem_req_valid  = !reset && !error && !redirect_valid && (in_use < CAP);
        imem_req_addr   = fetch_pc;
        req_fire        = imem_req_valid && imem_req_ready;
        push            = !reset && !redirect_valid && imem_resp_valid && (discard == '0);
        to_decode_valid = (count != '0) && !redirect_valid;
        pop             = to_decode_valid && to_decode_ready;
        to_decode_data  = (count != '0) ? mem_data[head] : 32'h0;
        to_decode_pc    = (count != '0) ? mem_pc[head] : 32'h0;
        fetch_error     = error;
        head_next       = (head == LAST_PTR) ? '0 : head + PW'(1);
        tail_next       = (tail == LAST_PTR) ? '0 : tail + PW'(1);
    end

    // Control state: PCs, in-flight/discard counters, buffer occupancy and the sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            error       <= 1'b0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding - CW'(imem_resp_valid);
            discard     <= outstanding - CW'(imem_resp_valid);
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                error <= 1'b1;
            end
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail_next;
            end
            if (pop) begin
                head <= head_next;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents are only visible while count is non-zero, so no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[tail] <= imem_resp_data;
            mem_pc[tail]   <= resp_pc;
        end
    end

    // The issue cap guarantees a free slot for every response memory can legally return
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(imem_resp_valid && (count == FULL)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=2, RESET_PC=0).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        to_decode_valid;
    logic        to_decode_ready;
    logic [31:0] to_decode_data;
    logic [31:0] to_decode_pc;
    logic        fetch_error;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .to_decode_valid (to_decode_valid),
        .to_decode_ready (to_decode_ready),
        .to_decode_data  (to_decode_data),
        .to_decode_pc    (to_decode_pc),
        .fetch_error     (fetch_error)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle's worth of inputs at the falling edge, then let outputs settle
    task automatic applyStimulus(input logic rst, input logic rq_rdy,
                                 input logic rsp_v, input logic [31:0] rsp_d,
                                 input logic rd_v, input logic [31:0] rd_pc,
                                 input logic dec_rdy);
        @(negedge clock);
        reset           = rst;
        imem_req_ready  = rq_rdy;
        imem_resp_valid = rsp_v;
        imem_resp_data  = rsp_d;
        redirect_valid  = rd_v;
        redirect_pc     = rd_pc;
        to_decode_ready = dec_rdy;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Request channel shorthand
    task automatic checkReq(input string tag, input logic v, input logic [31:0] a);
        checkOutput({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
        if (v) checkOutput({tag, ".req_addr"}, imem_req_addr, a);
    endtask

    // Decode channel shorthand
    task automatic checkDec(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] d);
        checkOutput({tag, ".dec_valid"}, {31'b0, to_decode_valid}, {31'b0, v});
        if (v) begin
            checkOutput({tag, ".dec_pc"}, to_decode_pc, pc);
            checkOutput({tag, ".dec_data"}, to_decode_data, d);
        end
    endtask

    // Linear directed sequence; each step is one clock cycle
    initial begin
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; to_decode_ready = 1'b0;

        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        checkReq("rst_hold", 0, 32'h0);

        // Streaming: memory always ready, 1-cycle responses, decode always ready
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c0", 1, 32'h0);
        checkDec("c0", 0, 32'h0, 32'h0);
        checkOutput("c0.dec_data_rst", to_decode_data, 32'h0);
        checkOutput("c0.dec_pc_rst", to_decode_pc, 32'h0);
        checkOutput("c0.err_rst", {31'b0, fetch_error}, 32'h0);
        applyStimulus(0, 1, 1, 32'hAAAA_0000, 0, 32'h0, 1);
        checkReq("c1", 1, 32'h4);
        checkDec("c1", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 32'hAAAA_0004, 0, 32'h0, 1);
        checkReq("c2", 0, 32'h0);
        checkDec("c2", 1, 32'h0, 32'hAAAA_0000);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c3", 1, 32'h8);
        checkDec("c3", 1, 32'h4, 32'hAAAA_0004);
        applyStimulus(0, 1, 1, 32'hAAAA_0008, 0, 32'h0, 1);
        checkReq("c4", 1, 32'hC);
        checkDec("c4", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 32'hAAAA_000C, 0, 32'h0, 1);
        checkReq("c5", 0, 32'h0);
        checkDec("c5", 1, 32'h8, 32'hAAAA_0008);

        // Decode stalls: buffer fills to two entries and issue stops
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkReq("c6", 1, 32'h10);
        checkDec("c6", 1, 32'hC, 32'hAAAA_000C);
        applyStimulus(0, 1, 1, 32'hAAAA_0010, 0, 32'h0, 0);
        checkReq("c7", 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkReq("c8_full", 0, 32'h0);
        checkDec("c8_full", 1, 32'hC, 32'hAAAA_000C);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c9", 0, 32'h0);
        checkDec("c9", 1, 32'hC, 32'hAAAA_000C);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c10", 1, 32'h14);
        checkDec("c10", 1, 32'h10, 32'hAAAA_0010);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkDec("c11_drained", 0, 32'h0, 32'h0);
        checkReq("c11", 1, 32'h14);

        // Two requests in flight, then redirect: both late responses must be dropped
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c12", 1, 32'h18);
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h100, 1);
        checkReq("c13_redir", 0, 32'h0);
        checkDec("c13_redir", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 32'hDEAD_0014, 0, 32'h0, 1);
        checkReq("c14", 0, 32'h0);
        checkDec("c14", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 32'hDEAD_0018, 0, 32'h0, 1);
        checkReq("c15", 1, 32'h100);
        checkDec("c15", 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 32'hAAAA_0100, 0, 32'h0, 1);
        checkDec("c16_dropped", 0, 32'h0, 32'h0);
        checkReq("c16", 1, 32'h104);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkDec("c17", 1, 32'h100, 32'hAAAA_0100);
        checkReq("c17", 1, 32'h104);

        // Redirect coinciding with a response and a buffered entry
        applyStimulus(0, 1, 1, 32'hDEAD_0104, 1, 32'h200, 1);
        checkReq("c18_redir", 0, 32'h0);
        checkDec("c18_redir", 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c19", 1, 32'h200);
        checkDec("c19_flushed", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c20", 1, 32'h200);
        applyStimulus(0, 0, 1, 32'hAAAA_0200, 0, 32'h0, 1);
        checkReq("c21", 1, 32'h204);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkDec("c22", 1, 32'h200, 32'hAAAA_0200);

        // Misaligned redirect with one request in flight
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c23", 1, 32'h204);
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h102, 1);
        checkOutput("c24.err", {31'b0, fetch_error}, 32'h0);
        applyStimulus(0, 1, 1, 32'hDEAD_0204, 0, 32'h0, 1);
        checkOutput("c25.err", {31'b0, fetch_error}, 32'h1);
        checkReq("c25", 0, 32'h0);
        checkDec("c25", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c26", 0, 32'h0);
        checkDec("c26_dropped", 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h300, 1);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("c28.err_sticky", {31'b0, fetch_error}, 32'h1);
        checkReq("c28", 0, 32'h0);

        // Reset clears the error and restarts at RESET_PC
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c29_in_reset", 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("c30.err", {31'b0, fetch_error}, 32'h0);
        checkReq("c30", 1, 32'h0);
        applyStimulus(0, 1, 1, 32'hBBBB_0000, 0, 32'h0, 0);
        checkReq("c31", 1, 32'h4);

        // Reset mid-operation: one request in flight, one entry buffered
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
        checkDec("c32_pre", 1, 32'h0, 32'hBBBB_0000);
        checkReq("c32", 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("c33.dec_valid", {31'b0, to_decode_valid}, 32'h0);
        checkOutput("c33.dec_data", to_decode_data, 32'h0);
        checkOutput("c33.dec_pc", to_decode_pc, 32'h0);
        checkOutput("c33.err", {31'b0, fetch_error}, 32'h0);
        checkReq("c33", 1, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
        checkReq("c34", 1, 32'h0);
        applyStimulus(0, 0, 1, 32'hCCCC_0000, 0, 32'h0, 1);
        checkDec("c35", 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        checkDec("c36", 1, 32'h0, 32'hCCCC_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
